// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte-offset width: word select bits plus the two ignored byte bits.
  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return 32 - off_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: async read port, per-word write port.
module icache_array #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 24,
  parameter int unsigned WRD_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [WRD_W-1:0] rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             fill_done,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             fill_valid
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  // Valid bits: cleared by reset or flush; flush wins over a completing fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[wr_idx] <= fill_valid;
    end
  end

  // Tag and data storage, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_word] <= wr_data;
    end
    if (fill_done) begin
      tag_q[wr_idx] <= fill_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with burst line refill.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] PC,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int unsigned OFF_W = off_w(WORDS);
  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(LINES, WORDS);
  localparam int unsigned WRD_W = OFF_W - 2;

  state_t           state_q;
  logic [WRD_W-1:0] cnt_q;
  logic             drop_q;

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [WRD_W-1:0] pc_word;
  logic [TAG_W-1:0] ref_tag;
  logic [IDX_W-1:0] ref_idx;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             miss;
  logic             beat;
  logic             last_beat;
  logic             unused_pc;

  assign pc_tag    = PC[31 -: TAG_W];
  assign pc_idx    = PC[OFF_W +: IDX_W];
  assign pc_word   = PC[OFF_W-1:2];
  assign unused_pc = ^PC[1:0];

  // The line being refilled is identified by the latched burst address.
  assign ref_tag = mem_addr[31 -: TAG_W];
  assign ref_idx = mem_addr[OFF_W +: IDX_W];

  assign hit       = rd_valid & (rd_tag == pc_tag);
  assign miss      = (state_q == IDLE) & fetch_en & ~hit;
  assign beat      = (state_q == REFILL) & mem_valid;
  assign last_beat = beat & (cnt_q == WRD_W'(WORDS - 1));

  icache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W),
    .WRD_W(WRD_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rd_idx    (pc_idx),
    .rd_word   (pc_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (beat),
    .wr_idx    (ref_idx),
    .wr_word   (cnt_q),
    .wr_data   (mem_rdata),
    .fill_done (last_beat),
    .fill_tag  (ref_tag),
    .fill_valid(~drop_q)
  );

  // Output muxing: NOP and stall throughout a refill, lookup result in IDLE.
  always_comb begin
    stall = 1'b1;
    instr = NOP_INSTR;
    if (state_q == IDLE) begin
      stall = fetch_en & ~hit;
      if (hit) begin
        instr = rd_data;
      end
    end
  end

  // Miss launch, beat counting and drop tracking for the refill burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            mem_addr <= {pc_tag, pc_idx, {OFF_W{1'b0}}};
            cnt_q    <= '0;
            mem_req  <= 1'b1;
            drop_q   <= flush;
            state_q  <= REFILL;
          end
        end
        REFILL: begin
          if (flush) begin
            drop_q <= 1'b1;
          end
          if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            // Completion clears drop; a flush on this same beat is still
            // honoured because the array gives flush priority over the fill.
            if (last_beat) begin
              drop_q  <= 1'b0;
              mem_req <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed tables plus randomized accesses
// against a line-content model of the cache.
module tb_icache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] PC;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  int tests = 0;
  int fails = 0;
  bit scramble = 1'b0;

  // Reference model: which lines hold which tag and words.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;
  vec_t tbl[$];

  icache #(.LINES(16), .WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .PC       (PC),
    .flush    (flush),
    .instr    (instr),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  // One fetch at pc starting at posedge+1; on a miss, serve the burst with
  // beats dbase+0..3 using the valid pattern vpat (LSB first, vlen cycles,
  // then always valid). Returns the number of cycles stall was high.
  task automatic access(input logic [31:0] pc, input bit fl, input logic [31:0] dbase,
                        input logic [7:0] vpat, input int vlen, input int flush_beat,
                        output int scyc);
    logic [31:0] base;
    bit          dropped;
    bit          exp_hit;
    int          beats;
    int          cyc;
    base     = pc & 32'hFFFF_FFF0;
    PC       = pc;
    fetch_en = 1'b1;
    flush    = fl;
    mem_valid = 1'b0;
    #1;
    exp_hit = m_hit(pc);
    chk("lookup_stall", 32'(stall), 32'(!exp_hit));
    chk("lookup_instr", instr, exp_hit ? m_data[pc[7:4]][pc[3:2]] : NOP);
    scyc = 0;
    if (exp_hit) begin
      tick();
      flush = 1'b0;
      if (fl) clear_model();
      return;
    end
    tick();
    flush   = 1'b0;
    dropped = fl;
    if (fl) clear_model();
    scyc  = 1;
    beats = 0;
    cyc   = 0;
    chk("mem_req_rise", 32'(mem_req), 32'd1);
    chk("mem_addr", mem_addr, base);
    while (beats < 4 && cyc < 64) begin
      mem_valid = (cyc < vlen) ? vpat[cyc[2:0]] : 1'b1;
      mem_rdata = dbase + 32'(beats);
      flush     = (beats == flush_beat) && mem_valid;
      if (scramble) PC = $urandom;
      #1;
      chk("refill_stall", 32'(stall), 32'd1);
      chk("refill_instr", instr, NOP);
      chk("refill_req", 32'(mem_req), 32'd1);
      chk("refill_addr", mem_addr, base);
      if (flush) dropped = 1'b1;
      if (mem_valid) beats++;
      tick();
      scyc++;
      cyc++;
    end
    if (beats < 4) chk("burst_timeout", 32'(beats), 32'd4);
    flush     = 1'b0;
    mem_valid = 1'b0;
    if (dropped) begin
      clear_model();
    end else begin
      m_valid[pc[7:4]] = 1'b1;
      m_tag[pc[7:4]]   = pc[31:8];
      for (int w = 0; w < 4; w++) m_data[pc[7:4]][w] = dbase + 32'(w);
    end
    PC       = pc;
    fetch_en = !dropped;
    #1;
    chk("post_stall", 32'(stall), 32'd0);
    chk("mem_req_fall", 32'(mem_req), 32'd0);
    if (!dropped) chk("post_instr", instr, dbase + 32'(pc[3:2]));
    tick();
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      PC        = tbl[i].pc;
      fetch_en  = 1'b1;
      flush     = 1'b0;
      mem_valid = 1'b0;
      #1;
      chk("tbl_stall", 32'(stall), 32'd0);
      chk("tbl_instr", instr, tbl[i].instr);
      tick();
    end
    tbl.delete();
  endtask

  initial begin
    int sc;
    rst = 1'b1; fetch_en = 1'b0; PC = '0; flush = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    clear_model();
    tick(); tick();
    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    fetch_en = 1'b1; #1;
    chk("rst_stall_fetch", 32'(stall), 32'd1);
    fetch_en = 1'b0; #1;
    rst = 1'b0;
    tick();

    // 1. Cold miss
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("cold_stall_cycles", 32'(sc), 32'd5);
    tbl.push_back('{32'h4, 32'hA1});
    tbl.push_back('{32'hC, 32'hA3});
    tbl.push_back('{32'h8, 32'hA2});
    tbl.push_back('{32'h0, 32'hA0});
    run_table();

    // 2. Conflict eviction
    access(32'h100, 1'b0, 32'hB0, 8'h00, 0, -1, sc);
    chk("evict_miss_cycles", 32'(sc), 32'd5);
    tbl.push_back('{32'h100, 32'hB0});
    tbl.push_back('{32'h10C, 32'hB3});
    run_table();
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("evict_rmiss_cycles", 32'(sc), 32'd5);
    access(32'h10, 1'b0, 32'hC0, 8'h00, 0, -1, sc);
    chk("idx1_miss_cycles", 32'(sc), 32'd5);
    access(32'h10, 1'b0, 32'hC0, 8'h00, 0, -1, sc);
    chk("idx1_hit_cycles", 32'(sc), 32'd0);

    // 3. Gapped burst: valid 1,0,0,1,0,1,1
    access(32'h20, 1'b0, 32'hD0, 8'b0110_1001, 7, -1, sc);
    chk("gap_stall_cycles", 32'(sc), 32'd8);
    tbl.push_back('{32'h20, 32'hD0});
    tbl.push_back('{32'h24, 32'hD1});
    tbl.push_back('{32'h28, 32'hD2});
    tbl.push_back('{32'h2C, 32'hD3});
    run_table();

    // 4. Flush in IDLE
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("pre_flush_hit", 32'(sc), 32'd0);
    fetch_en = 1'b0; flush = 1'b1; #1;
    tick();
    flush = 1'b0;
    clear_model();
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("post_flush_miss", 32'(sc), 32'd5);

    // 5. Flush alongside beat 2
    access(32'h40, 1'b0, 32'hE0, 8'h00, 0, 2, sc);
    chk("midflush_cycles", 32'(sc), 32'd5);
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("midflush_l0_miss", 32'(sc), 32'd5);
    access(32'h40, 1'b0, 32'hE0, 8'h00, 0, -1, sc);
    chk("midflush_drop_miss", 32'(sc), 32'd5);

    // 6. Async reset during beat 1
    PC = 32'h50; fetch_en = 1'b1; flush = 1'b0; mem_valid = 1'b0; #1;
    tick();
    mem_valid = 1'b1; mem_rdata = 32'hF0;
    tick();
    mem_rdata = 32'hF1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_instr", instr, NOP);
    chk("arst_stall", 32'(stall), 32'd1);
    mem_valid = 1'b0; fetch_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_model();
    tick();
    access(32'h50, 1'b0, 32'hF0, 8'h00, 0, -1, sc);
    chk("arst_line_miss", 32'(sc), 32'd5);
    access(32'h0, 1'b0, 32'hA0, 8'h00, 0, -1, sc);
    chk("arst_l0_miss", 32'(sc), 32'd5);

    // Randomized accesses against the model
    scramble = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        fetch_en = 1'b0;
        flush    = ($urandom_range(0, 3) == 0);
        PC       = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        tick();
        if (flush) clear_model();
        flush = 1'b0;
      end else begin
        logic [31:0] pc;
        pc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
                 ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
        access(pc, ($urandom_range(0, 19) == 0), $urandom, 8'($urandom),
               int'($urandom_range(0, 8)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, sc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
